pipe_divider: RTL and testbench

PIPE_DIVIDER -- requirements
Module: pipe_divider

---
 rtl/pipe_divider_pkg.sv | 23 ++
 rtl/pipe_divider_div_stage.sv | 54 +++++
 rtl/pipe_divider.sv | 138 +++++++++++++
 tb/tb_pipe_divider.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_divider_pkg.sv
// Shared constants and helpers for the pipelined restoring divider.
package pipe_divider_pkg;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 24;
  localparam int SIGNED_DEF     = 1;
  localparam int TAG_W_DEF      = 4;
  localparam int MAX_W          = 64;

  // input stage + one stage per quotient bit + output stage
  function automatic int latency(input int dividend_w);
    return dividend_w + 2;
  endfunction

  function automatic logic [MAX_W-1:0] most_neg(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] most_pos(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_divider_div_stage.sv
// One restoring-division step: resolves quotient bit DIVIDEND_W-1-K.
module div_stage
  import pipe_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int SB_W       = 1,
  parameter int K          = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic [DIVIDEND_W+DIVISOR_W-1:0] rem,
  input  logic [DIVIDEND_W-1:0]           quo,
  input  logic [DIVISOR_W-1:0]            dvs,
  input  logic [SB_W-1:0]                 sb,
  output logic [DIVIDEND_W+DIVISOR_W-1:0] rem_q,
  output logic [DIVIDEND_W-1:0]           quo_q,
  output logic [DIVISOR_W-1:0]            dvs_q,
  output logic [SB_W-1:0]                 sb_q
);

  localparam int RW = DIVIDEND_W + DIVISOR_W;
  localparam int SH = DIVIDEND_W - 1 - K;

  logic [RW-1:0]         dsh, rem_n;
  logic [DIVIDEND_W-1:0] quo_n;
  logic                  ge;

  // full-width compare so the shifted divisor never loses its top bits
  assign dsh = RW'(dvs) << SH;
  assign ge  = rem >= dsh;

  always_comb begin
    rem_n     = ge ? rem - dsh : rem;
    quo_n     = quo;
    quo_n[SH] = ge;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sb_q  <= '0;
    end else if (en) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      dvs_q <= dvs;
      sb_q  <= sb;
    end
  end

endmodule

// File: rtl/pipe_divider.sv
// Pipelined restoring divider: sign-strip input stage, one stage per quotient
// bit, sign-fixup output stage; one result per cycle under a global stall.
module pipe_divider
  import pipe_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int SIGNED     = SIGNED_DEF,
  parameter int TAG_W      = TAG_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ivalid,
  output logic                  iready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic [TAG_W-1:0]      itag,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic [TAG_W-1:0]      otag,
  output logic                  dbz,
  output logic                  ovf
);

  localparam int RW     = DIVIDEND_W + DIVISOR_W;
  localparam int STAGES = latency(DIVIDEND_W) - 1;
  // sideband: {tag, neg_q, neg_r, dbz, ovf, dividend[DIVISOR_W-1:0]}
  localparam int SB_OVF = DIVISOR_W;
  localparam int SB_DBZ = DIVISOR_W + 1;
  localparam int SB_NR  = DIVISOR_W + 2;
  localparam int SB_NQ  = DIVISOR_W + 3;
  localparam int SB_W   = DIVISOR_W + 4 + TAG_W;
  localparam logic [DIVIDEND_W-1:0] MN = DIVIDEND_W'(most_neg(DIVIDEND_W));
  localparam logic [DIVIDEND_W-1:0] MP = DIVIDEND_W'(most_pos(DIVIDEND_W));

  logic              en;
  logic [STAGES:0]   vld_pipe;

  assign en     = !vld_pipe[STAGES] || oready;
  assign iready = en;
  assign ovalid = vld_pipe[STAGES];

  logic                  sgn_dd, sgn_dv, dbz_in, ovf_in;
  logic [DIVIDEND_W-1:0] mag_dd;
  logic [DIVISOR_W-1:0]  mag_dv;

  assign sgn_dd = (SIGNED != 0) && dividend[DIVIDEND_W-1];
  assign sgn_dv = (SIGNED != 0) && divisor[DIVISOR_W-1];
  assign mag_dd = sgn_dd ? -dividend : dividend;
  assign mag_dv = sgn_dv ? -divisor : divisor;
  assign dbz_in = divisor == '0;
  assign ovf_in = (SIGNED != 0) && (dividend == MN) && (divisor == '1);

  logic [RW-1:0]        rem0;
  logic [DIVISOR_W-1:0] dvs0;
  logic [SB_W-1:0]      sb0;

  logic [DIVIDEND_W:0][RW-1:0]         rem_p;
  logic [DIVIDEND_W:0][DIVIDEND_W-1:0] quo_p;
  logic [DIVIDEND_W:0][DIVISOR_W-1:0]  dvs_p;
  logic [DIVIDEND_W:0][SB_W-1:0]       sb_p;

  assign rem_p[0] = rem0;
  assign quo_p[0] = '0;
  assign dvs_p[0] = dvs0;
  assign sb_p[0]  = sb0;

  for (genvar k = 0; k < DIVIDEND_W; k++) begin : g_stage
    div_stage #(
      .DIVIDEND_W(DIVIDEND_W),
      .DIVISOR_W (DIVISOR_W),
      .SB_W      (SB_W),
      .K         (k)
    ) u_stage (
      .clock(clock),
      .reset(reset),
      .en   (en),
      .rem  (rem_p[k]),
      .quo  (quo_p[k]),
      .dvs  (dvs_p[k]),
      .sb   (sb_p[k]),
      .rem_q(rem_p[k+1]),
      .quo_q(quo_p[k+1]),
      .dvs_q(dvs_p[k+1]),
      .sb_q (sb_p[k+1])
    );
  end

  logic [SB_W-1:0]       sb_f;
  logic [DIVIDEND_W-1:0] q_mag, q_n;
  logic [DIVISOR_W-1:0]  r_mag, r_n;
  logic                  unused_tail;

  assign sb_f        = sb_p[DIVIDEND_W];
  assign q_mag       = quo_p[DIVIDEND_W];
  assign r_mag       = rem_p[DIVIDEND_W][DIVISOR_W-1:0];
  assign unused_tail = ^{rem_p[DIVIDEND_W][RW-1:DIVISOR_W], dvs_p[DIVIDEND_W]};

  always_comb begin
    q_n = sb_f[SB_NQ] ? -q_mag : q_mag;
    r_n = sb_f[SB_NR] ? -r_mag : r_mag;
    if (sb_f[SB_DBZ]) begin
      q_n = (SIGNED != 0) ? (sb_f[SB_NR] ? MN : MP) : '1;
      r_n = sb_f[DIVISOR_W-1:0];
    end else if (sb_f[SB_OVF]) begin
      q_n = MN;
      r_n = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      rem0      <= '0;
      dvs0      <= '0;
      sb0       <= '0;
      quotient  <= '0;
      remainder <= '0;
      otag      <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], ivalid};
      rem0      <= RW'(mag_dd);
      dvs0      <= mag_dv;
      sb0       <= {itag, sgn_dd ^ sgn_dv, sgn_dd, dbz_in, ovf_in,
                    dividend[DIVISOR_W-1:0]};
      quotient  <= q_n;
      remainder <= r_n;
      otag      <= sb_f[SB_W-1 -: TAG_W];
      dbz       <= sb_f[SB_DBZ];
      ovf       <= sb_f[SB_OVF];
    end
  end

endmodule

// File: tb/tb_pipe_divider.sv
// Randomized bench for pipe_divider against an arithmetic truncating-division model.
module tb_pipe_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        ivalid, iready, ovalid, oready, dbz, ovf;
  logic [31:0] dividend, quotient;
  logic [23:0] divisor, remainder;
  logic [3:0]  itag, otag;

  logic        u_ivalid, u_iready, u_ovalid, u_oready, u_dbz, u_ovf;
  logic [31:0] u_dividend, u_quotient;
  logic [23:0] u_divisor, u_remainder;
  logic [3:0]  u_itag, u_otag;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] q;
    logic [23:0] r;
    logic [3:0]  t;
    logic        dbz;
    logic        ovf;
  } res_t;

  res_t expq[$];

  always #5 clock = ~clock;

  pipe_divider #(.DIVIDEND_W(32), .DIVISOR_W(24), .SIGNED(1), .TAG_W(4)) u_dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready),
    .dividend(dividend), .divisor(divisor), .itag(itag), .ovalid(ovalid),
    .oready(oready), .quotient(quotient), .remainder(remainder), .otag(otag),
    .dbz(dbz), .ovf(ovf)
  );

  pipe_divider #(.DIVIDEND_W(32), .DIVISOR_W(24), .SIGNED(0), .TAG_W(4)) u_dut_u (
    .clock(clock), .reset(reset), .ivalid(u_ivalid), .iready(u_iready),
    .dividend(u_dividend), .divisor(u_divisor), .itag(u_itag), .ovalid(u_ovalid),
    .oready(u_oready), .quotient(u_quotient), .remainder(u_remainder), .otag(u_otag),
    .dbz(u_dbz), .ovf(u_ovf)
  );

  function automatic res_t ref_div(input logic [31:0] a, input logic [23:0] b,
                                   input logic [3:0] t, input bit sgn);
    res_t   e;
    longint na, nb;
    na    = sgn ? longint'($signed(a)) : longint'(a);
    nb    = sgn ? longint'($signed(b)) : longint'(b);
    e.t   = t;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (nb == 0) begin
      e.dbz = 1'b1;
      e.r   = a[23:0];
      e.q   = !sgn ? 32'hFFFFFFFF : (na < 0 ? 32'h80000000 : 32'h7FFFFFFF);
    end else begin
      e.q   = 32'(na / nb);
      e.r   = 24'(na % nb);
      e.ovf = sgn && (a == 32'h80000000) && (nb == -1);
    end
    return e;
  endfunction

  task automatic rnd_op(output logic [31:0] a, output logic [23:0] b);
    int sel;
    sel = $urandom_range(0, 9);
    a   = $urandom;
    case (sel)
      0: b = 24'($urandom_range(1, 15));
      1: b = -24'($urandom_range(1, 15));
      2: b = '0;
      3: begin a = 32'h80000000; b = 24'hFFFFFF; end
      4: a = 32'($urandom_range(0, 1000));
      default: b = 24'($urandom);
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // single operation on an idle pipe; lat = cycles from acceptance to ovalid
  task automatic run_one(input bit uns, input logic [31:0] a, input logic [23:0] b,
                         input logic [3:0] t, output res_t got, output int lat);
    logic ov;
    if (uns) begin
      u_dividend = a; u_divisor = b; u_itag = t; u_ivalid = 1'b1;
    end else begin
      dividend = a; divisor = b; itag = t; ivalid = 1'b1;
    end
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin ivalid = 1'b0; u_ivalid = 1'b0; end
      ov = uns ? u_ovalid : ovalid;
    end while (!ov && lat < 100);
    got.q   = uns ? u_quotient  : quotient;
    got.r   = uns ? u_remainder : remainder;
    got.t   = uns ? u_otag      : otag;
    got.dbz = uns ? u_dbz       : dbz;
    got.ovf = uns ? u_ovf       : ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; ivalid = 1'b0; u_ivalid = 1'b0; oready = 1'b1; u_oready = 1'b1;
    dividend = '0; divisor = '0; itag = '0;
    u_dividend = '0; u_divisor = '0; u_itag = '0;
    tick();
    tests++;
    if ({ovalid, u_ovalid} !== 2'b00) begin
      fails++; $display("FAIL reset_ovalid: got %b want 00", {ovalid, u_ovalid});
    end
    tests++;
    if ({quotient, remainder, otag, dbz, ovf} !== 62'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {quotient, remainder, otag, dbz, ovf});
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if (iready !== 1'b1) begin
      fails++; $display("FAIL reset_iready: got %b want 1", iready);
    end
  endtask

  task automatic test_signed_basic();
    logic [31:0] a[3] = '{32'(-100), 32'd100, 32'(-100)};
    logic [23:0] b[3] = '{24'd7, 24'(-7), 24'(-7)};
    logic [31:0] q[3] = '{32'(-14), 32'(-14), 32'd14};
    logic [23:0] r[3] = '{24'(-2), 24'd2, 24'(-2)};
    res_t got;
    int   lat;
    tick();
    for (int i = 0; i < 3; i++) begin
      run_one(1'b0, a[i], b[i], 4'(i + 3), got, lat);
      tests++;
      if (lat !== 34) begin
        fails++; $display("FAIL basic_latency[%0d]: got %0d want 34", i, lat);
      end
      tests++;
      if ({got.q, got.r, got.t, got.dbz, got.ovf} !== {q[i], r[i], 4'(i + 3), 2'b00}) begin
        fails++;
        $display("FAIL basic_result[%0d]: got q=%h r=%h t=%h dbz=%b ovf=%b want q=%h r=%h t=%h dbz=0 ovf=0",
                 i, got.q, got.r, got.t, got.dbz, got.ovf, q[i], r[i], 4'(i + 3));
      end
    end
  endtask

  task automatic test_dbz_ovf();
    logic [31:0] a[5] = '{32'd5, 32'(-5), 32'h80000000, 32'h80000000, 32'h80000000};
    logic [23:0] b[5] = '{24'd0, 24'd0, 24'hFFFFFF, 24'd1, 24'd0};
    logic [31:0] q[5] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [23:0] r[5] = '{24'd5, 24'hFFFFFB, 24'd0, 24'd0, 24'd0};
    logic [1:0]  f[5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b10};
    res_t got;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      run_one(1'b0, a[i], b[i], 4'(i), got, lat);
      tests++;
      if ({got.q, got.r, got.dbz, got.ovf} !== {q[i], r[i], f[i]}) begin
        fails++;
        $display("FAIL dbz_ovf[%0d]: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                 i, got.q, got.r, got.dbz, got.ovf, q[i], r[i], f[i][1], f[i][0]);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] a[4] = '{32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'hDEADBEEF};
    logic [23:0] b[4] = '{24'h000010, 24'h800000, 24'h000000, 24'hFFFFFF};
    res_t got, e;
    int   lat;
    logic [31:0] ra;
    logic [23:0] rb;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin ra = a[i]; rb = b[i]; end
      else rnd_op(ra, rb);
      e = ref_div(ra, rb, 4'(i), 1'b0);
      if (i == 0) begin
        e.q = 32'h0FFFFFFF; e.r = 24'hF; e.dbz = 1'b0; e.ovf = 1'b0;
      end
      run_one(1'b1, ra, rb, 4'(i), got, lat);
      tests++;
      if ({got.q, got.r, got.t, got.dbz, got.ovf} !== {e.q, e.r, e.t, e.dbz, e.ovf}) begin
        fails++;
        $display("FAIL unsigned[%0d]: %h/%h got q=%h r=%h t=%h dbz=%b ovf=%b want q=%h r=%h t=%h dbz=%b ovf=%b",
                 i, ra, rb, got.q, got.r, got.t, got.dbz, got.ovf, e.q, e.r, e.t, e.dbz, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pushed = 0, popped = 0, first = -1, last = -1, cyc = 0;
    logic [31:0] a;
    logic [23:0] b;
    res_t e;
    oready = 1'b1;
    expq.delete();
    while (popped < 40 && cyc < 200) begin
      if (ovalid && oready) begin
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL b2b_extra: got unexpected result q=%h want none", quotient);
        end else begin
          e = expq.pop_front();
          if ({quotient, remainder, otag, dbz, ovf} !== {e.q, e.r, e.t, e.dbz, e.ovf}) begin
            fails++;
            $display("FAIL b2b_result[%0d]: got q=%h r=%h t=%h dbz=%b ovf=%b want q=%h r=%h t=%h dbz=%b ovf=%b",
                     popped, quotient, remainder, otag, dbz, ovf, e.q, e.r, e.t, e.dbz, e.ovf);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        popped++;
      end
      if (pushed < 40) begin
        rnd_op(a, b);
        dividend = a; divisor = b; itag = 4'($urandom); ivalid = 1'b1;
        if (iready) begin
          expq.push_back(ref_div(a, b, itag, 1'b1));
          pushed++;
        end
      end else ivalid = 1'b0;
      tick();
      cyc++;
    end
    ivalid = 1'b0;
    tests++;
    if (popped !== 40) begin
      fails++; $display("FAIL b2b_count: got %0d want 40", popped);
    end
    tests++;
    if (last - first !== 39) begin
      fails++; $display("FAIL b2b_consecutive: got span %0d want 39", last - first);
    end
    tests++;
    if (first !== 34) begin
      fails++; $display("FAIL b2b_first_latency: got %0d want 34", first);
    end
  endtask

  task automatic test_backpressure();
    int pushed = 0, popped = 0, cyc = 0, idle_ov = 0;
    bit saw_full = 0;
    logic [31:0] a;
    logic [23:0] b;
    res_t e;
    expq.delete();
    while (popped < 80 && cyc < 400) begin
      oready = !(cyc >= 20 && cyc < 70);
      #1;
      if (!iready && !saw_full) begin
        saw_full = 1;
        tests++;
        if (pushed !== 34) begin
          fails++; $display("FAIL bp_fill_depth: got %0d accepted want 34", pushed);
        end
      end
      if (ovalid) begin
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL bp_extra: got unexpected q=%h want none", quotient);
        end else begin
          e = oready ? expq.pop_front() : expq[0];
          if ({quotient, remainder, otag, dbz, ovf} !== {e.q, e.r, e.t, e.dbz, e.ovf}) begin
            fails++;
            $display("FAIL bp_result[%0d] oready=%b: got q=%h r=%h t=%h dbz=%b ovf=%b want q=%h r=%h t=%h dbz=%b ovf=%b",
                     popped, oready, quotient, remainder, otag, dbz, ovf, e.q, e.r, e.t, e.dbz, e.ovf);
          end
          if (oready) popped++;
        end
      end
      if (pushed < 80) begin
        rnd_op(a, b);
        dividend = a; divisor = b; itag = 4'($urandom); ivalid = 1'b1;
        if (iready) begin
          expq.push_back(ref_div(a, b, itag, 1'b1));
          pushed++;
        end
      end else ivalid = 1'b0;
      tick();
      cyc++;
    end
    ivalid = 1'b0;
    oready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (ovalid) idle_ov++;
      tick();
    end
    tests++;
    if (!saw_full) begin
      fails++; $display("FAIL bp_iready_fall: got iready never 0 want 0 while full");
    end
    tests++;
    if (popped !== 80 || expq.size() !== 0 || idle_ov !== 0) begin
      fails++;
      $display("FAIL bp_count: got popped=%0d left=%0d extra=%0d want 80/0/0", popped, expq.size(), idle_ov);
    end
  endtask

  task automatic test_reset_flight();
    int cnt = 0, n = 0;
    logic [31:0] a;
    logic [23:0] b;
    oready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rnd_op(a, b);
      dividend = a; divisor = b; itag = 4'(i); ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    while (!ovalid && n < 100) begin tick(); n++; end
    tests++;
    if (ovalid !== 1'b1) begin
      fails++; $display("FAIL flight_precondition: got ovalid=%b want 1", ovalid);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({ovalid, quotient, remainder, otag, dbz, ovf} !== 63'd0) begin
      fails++; $display("FAIL flight_async_clear: got %h want 0", {ovalid, quotient, remainder, otag, dbz, ovf});
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    oready = 1'b1;
    #1;
    tests++;
    if (iready !== 1'b1) begin
      fails++; $display("FAIL flight_iready: got %b want 1", iready);
    end
    for (int i = 0; i < 60; i++) begin
      if (ovalid) cnt++;
      tick();
    end
    tests++;
    if (cnt !== 0) begin
      fails++; $display("FAIL flight_ghosts: got %0d results want 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_dbz_ovf();
    test_unsigned();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
